// File: rtl/ps2_host_ctrl.sv
// PS/2 host port controller: receives and checks device frames, and sends the
// two-byte LED update (0xED, leds) with ACK/RESEND handling, timeout and retries.
module ps2_host_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_MS = 20,
  parameter int MAX_RETRY  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       led_req,
  input  logic [2:0] led_val,
  output logic       led_busy,
  output logic       led_done,
  output logic       led_err,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_perr
);
  localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int RXCLR_CYC   = CLK_HZ / 1000 * 2;
  localparam logic [7:0] CMD_LED = 8'hED;
  localparam logic [7:0] RSP_ACK = 8'hFA;
  localparam logic [7:0] RSP_NAK = 8'hFE;

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, TX_BITS, TX_ACK, WAIT_ACK} state_t;
  typedef struct packed {
    logic       good;
    logic [7:0] data;
  } rx_frm_t;

  state_t      state, nxt;
  logic [1:0]  clk_sy, dat_sy;
  logic        clk_prev, fall, dat;
  logic [3:0]  rx_cnt;
  logic [9:0]  rx_sr;
  logic [31:0] rx_idle;
  logic        rx_frz, frame_done, is_hs;
  rx_frm_t     frm;
  logic        pending, byte_sel, tx_drv, ack, fail;
  logic [7:0]  att, cur_byte;
  logic [31:0] tmr;
  logic [2:0]  val_q;
  logic [8:0]  tx_sr;
  logic [3:0]  tx_cnt;

  // Pins idle high, so synchronizers reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sy   <= 2'b11;
      dat_sy   <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sy   <= {clk_sy[0], ps2_clk_i};
      dat_sy   <= {dat_sy[0], ps2_data_i};
      clk_prev <= clk_sy[1];
    end
  end

  assign fall = clk_prev & ~clk_sy[1];
  assign dat  = dat_sy[1];

  // Receive path; rx_sr holds the first ten bits, dat supplies the stop bit.
  assign rx_frz     = state inside {INHIBIT, REQ, TX_BITS, TX_ACK};
  assign frame_done = fall & ~rx_frz & (rx_cnt == 4'd10);
  assign frm.good   = ~rx_sr[0] & dat & (^rx_sr[9:1]);
  assign frm.data   = rx_sr[8:1];
  assign is_hs      = (frm.data == RSP_ACK) || (frm.data == RSP_NAK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      rx_sr    <= '0;
      rx_idle  <= '0;
      rx_valid <= 1'b0;
      rx_perr  <= 1'b0;
      rx_byte  <= '0;
    end else begin
      rx_valid <= frame_done & frm.good & ~is_hs;
      rx_perr  <= frame_done & ~frm.good;
      if (frame_done && frm.good && !is_hs) rx_byte <= frm.data;
      if (rx_frz) begin
        rx_cnt  <= '0;
        rx_idle <= '0;
      end else if (fall) begin
        rx_idle <= '0;
        rx_sr   <= {dat, rx_sr[9:1]};
        rx_cnt  <= (rx_cnt == 4'd10) ? 4'd0 : rx_cnt + 4'd1;
      end else if (rx_cnt != 4'd0) begin
        if (rx_idle == 32'(RXCLR_CYC - 1)) rx_cnt <= '0;
        else rx_idle <= rx_idle + 32'd1;
      end
    end
  end

  assign cur_byte = byte_sel ? {5'b0, val_q} : CMD_LED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt  = state;
    ack  = 1'b0;
    fail = 1'b0;
    unique case (state)
      IDLE:     if (pending && rx_cnt == 4'd0) nxt = INHIBIT;
      INHIBIT:  if (tmr == 32'(INHIBIT_CYC - 1)) nxt = REQ;
      REQ:      nxt = TX_BITS;
      TX_BITS:  if (fall && tx_cnt == 4'd9) nxt = TX_ACK;
      TX_ACK:   if (fall) begin
                  if (dat) fail = 1'b1;
                  else     nxt  = WAIT_ACK;
                end
      WAIT_ACK: if (frame_done) begin
                  if (!frm.good || frm.data == RSP_NAK) fail = 1'b1;
                  else if (frm.data == RSP_ACK)         ack  = 1'b1;
                end
      default:  nxt = IDLE;
    endcase
    // An ACK landing on the expiry cycle still counts.
    if (state inside {REQ, TX_BITS, TX_ACK, WAIT_ACK} &&
        tmr == 32'(TIMEOUT_CYC - 1) && !ack)
      fail = 1'b1;
    if (ack)  nxt = byte_sel ? IDLE : INHIBIT;
    if (fail) nxt = (att <= 8'(MAX_RETRY)) ? INHIBIT : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      byte_sel <= 1'b0;
      att      <= '0;
      tmr      <= '0;
      val_q    <= '0;
      tx_sr    <= '0;
      tx_cnt   <= '0;
      tx_drv   <= 1'b0;
      led_done <= 1'b0;
      led_err  <= 1'b0;
    end else begin
      led_done <= 1'b0;
      led_err  <= 1'b0;
      if (led_req && !pending) pending <= 1'b1;
      // One timer serves both the inhibit hold and the per-attempt timeout.
      if (state == IDLE || (nxt != state && (nxt == INHIBIT || nxt == REQ))) tmr <= '0;
      else tmr <= tmr + 32'd1;
      if (state == IDLE && nxt == INHIBIT) begin
        val_q    <= led_val;
        byte_sel <= 1'b0;
        att      <= 8'd1;
      end
      if (state == REQ) begin
        tx_sr  <= {~^cur_byte, cur_byte};
        tx_cnt <= '0;
        tx_drv <= 1'b1;
      end else if (state == TX_BITS && fall) begin
        tx_drv <= ~tx_sr[0];
        tx_sr  <= {1'b1, tx_sr[8:1]};
        tx_cnt <= tx_cnt + 4'd1;
      end
      if (ack) begin
        if (byte_sel) begin
          led_done <= 1'b1;
          pending  <= 1'b0;
        end else begin
          byte_sel <= 1'b1;
          att      <= 8'd1;
        end
      end
      if (fail) begin
        if (att <= 8'(MAX_RETRY)) att <= att + 8'd1;
        else begin
          led_err <= 1'b1;
          pending <= 1'b0;
        end
      end
    end
  end

  assign led_busy    = pending;
  assign ps2_clk_oe  = (state == INHIBIT);
  assign ps2_data_oe = (state == REQ) || (state == TX_BITS && tx_drv);

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: PS/2 device model on the open-drain lines, a scoreboard
// of expected output events, and a monitor that checks events as they appear.
`timescale 1ns/1ps
module tb_ps2_host_ctrl;
  localparam int INH = 100;
  localparam int TMO = 20000;
  localparam int EV_RX = 0, EV_PERR = 1, EV_DONE = 2, EV_ERR = 3;

  typedef struct {
    int         kind;
    logic [7:0] b;
  } ev_t;

  logic       clk = 1'b0, rst_n = 1'b1;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       ps2_clk_line, ps2_data_line;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       led_req = 1'b0;
  logic [2:0] led_val = 3'b000;
  logic       led_busy, led_done, led_err, rx_valid, rx_perr;
  logic [7:0] rx_byte;

  ev_t        expq[$];
  int         req_t[$];
  int         tests = 0, fails = 0, cyc = 0, inh_run = 0, oe_cnt = 0;
  logic [7:0] exp_last = 8'h00;

  assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_line = dev_dat & ~ps2_data_oe;

  ps2_host_ctrl #(.CLK_HZ(1_000_000), .INHIBIT_US(100), .TIMEOUT_MS(20), .MAX_RETRY(3)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk_i(ps2_clk_line), .ps2_data_i(ps2_data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .led_req(led_req), .led_val(led_val),
    .led_busy(led_busy), .led_done(led_done), .led_err(led_err), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .rx_perr(rx_perr)
  );

  always #500 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input bit ok, input string nm, input int act, input int exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic push_ev(input int k, input logic [7:0] b);
    ev_t e;
    e.kind = k;
    e.b    = b;
    expq.push_back(e);
  endtask

  task automatic chk_ev(input int k, input logic [7:0] b);
    ev_t e;
    if (expq.size() == 0) begin
      check(1'b0, "unexpected_event", k, -1);
    end else begin
      e = expq.pop_front();
      check(e.kind == k, "event_kind", k, e.kind);
      if (k == EV_RX) check(b == e.b, "rx_byte_at_valid", b, e.b);
    end
  endtask

  // Scoreboard monitor: every output pulse must match the head of the queue.
  always @(negedge clk) if (rst_n) begin
    if (rx_valid) chk_ev(EV_RX, rx_byte);
    if (rx_perr)  chk_ev(EV_PERR, 8'h00);
    if (led_done) begin
      chk_ev(EV_DONE, 8'h00);
      check(led_busy == 1'b0, "busy_drops_with_done", led_busy, 0);
    end
    if (led_err)  chk_ev(EV_ERR, 8'h00);
  end

  // Inhibit-length and attempt-start monitor.
  always @(negedge clk) begin
    if (ps2_clk_oe || ps2_data_oe) oe_cnt++;
    if (!rst_n) inh_run = 0;
    else if (ps2_clk_oe) inh_run++;
    else if (inh_run > 0) begin
      check(inh_run == INH, "inhibit_len", inh_run, INH);
      check(ps2_data_oe == 1'b1, "req_start_bit", ps2_data_oe, 1);
      req_t.push_back(cyc);
      inh_run = 0;
    end
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bpar,
                                           input bit bstart, input bit bstop);
    return {~bstop, (~^b) ^ bpar, b, bstart};
  endfunction

  // Reference model: what the host should report for a device frame outside a handshake.
  task automatic expect_frame(input logic [10:0] f);
    int ones = 0;
    for (int i = 1; i <= 9; i++) ones += int'(f[i]);
    if (f[0] != 1'b0 || f[10] != 1'b1 || (ones % 2) != 1) push_ev(EV_PERR, 8'h00);
    else if (f[8:1] != 8'hFA && f[8:1] != 8'hFE) begin
      push_ev(EV_RX, f[8:1]);
      exp_last = f[8:1];
    end
  endtask

  task automatic dev_send(input logic [10:0] f);
    for (int i = 0; i < 11; i++) begin
      dev_dat = f[i];
      #20_000 dev_clk = 1'b0;
      #20_000 dev_clk = 1'b1;
    end
    dev_dat = 1'b1;
  endtask

  // Device side of a host->device byte: clock it in and ACK it.
  task automatic dev_recv(output logic [7:0] b, output bit ok);
    logic [9:0] bits;
    int n;
    n = 0;
    bits = '0;
    b = 8'h00;
    ok = 1'b0;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30000) begin
      check(1'b0, "req_wait_timeout", n, 0);
      return;
    end
    #10_000;
    for (int k = 0; k < 10; k++) begin
      dev_clk = 1'b0;
      #20_000 dev_clk = 1'b1;
      #10_000 bits[k] = ps2_data_line;
      if (k == 9) dev_dat = 1'b0;
      #10_000;
    end
    dev_clk = 1'b0;
    #20_000 dev_clk = 1'b1;
    #10_000 dev_dat = 1'b1;
    b  = bits[7:0];
    ok = bits[9] && (^bits[8:0]);
  endtask

  task automatic pulse_req(input logic [2:0] v);
    @(negedge clk);
    led_val = v;
    led_req = 1'b1;
    @(negedge clk);
    led_req = 1'b0;
  endtask

  task automatic wait_drain(input int lim, input string nm);
    int n = 0;
    while (expq.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(expq.size() == 0, nm, expq.size(), 0);
  endtask

  initial begin
    #250_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [10:0] f;
    logic [2:0]  v;
    bit          ok;
    int          oe0, n0, ed_cnt, r;

    #2000 rst_n = 1'b0;
    #3000 @(negedge clk);
    check({ps2_clk_oe, ps2_data_oe, led_busy, led_done, led_err, rx_valid, rx_perr, rx_byte} == '0,
          "reset_outputs", int'(rx_byte), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: good 0x1C; 2: parity flipped
    oe0 = oe_cnt;
    f = mk_frame(8'h1C, 0, 0, 0);
    expect_frame(f);
    dev_send(f);
    #50_000 check(rx_byte == 8'h1C, "rx_byte_1c", rx_byte, 8'h1C);
    f = mk_frame(8'h1C, 1, 0, 0);
    expect_frame(f);
    dev_send(f);
    #50_000 check(rx_byte == 8'h1C, "rx_byte_hold_perr", rx_byte, 8'h1C);

    // random device frames with occasional corruption
    for (int i = 0; i < 4; i++) begin
      do b = 8'($urandom_range(0, 255)); while (b == 8'hFA || b == 8'hFE);
      r = $urandom_range(0, 5);
      f = mk_frame(b, r == 0, r == 1, r == 2);
      expect_frame(f);
      dev_send(f);
      #50_000 check(rx_byte == exp_last, "rx_byte_random", rx_byte, exp_last);
    end
    wait_drain(100, "rx_events_drained");
    check(oe_cnt == oe0, "no_drive_during_rx", oe_cnt - oe0, 0);

    // 3: LED update 3'b101
    push_ev(EV_DONE, 8'h00);
    pulse_req(3'b101);
    check(led_busy == 1'b1, "busy_after_req", led_busy, 1);
    dev_recv(b, ok);
    check(ok && b == 8'hED, "tx_byte0", b, 8'hED);
    #50_000 dev_send(mk_frame(8'hFA, 0, 0, 0));
    dev_recv(b, ok);
    check(ok && b == 8'h05, "tx_byte1", b, 8'h05);
    #50_000 dev_send(mk_frame(8'hFA, 0, 0, 0));
    wait_drain(200, "led_done_seen");
    check({ps2_clk_oe, ps2_data_oe, led_busy} == 3'b000, "released_after_done",
          {ps2_clk_oe, ps2_data_oe, led_busy}, 0);

    // 4: two RESENDs then ACK, random LED value
    v = 3'($urandom_range(0, 7));
    push_ev(EV_DONE, 8'h00);
    pulse_req(v);
    ed_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      dev_recv(b, ok);
      if (ok && b == 8'hED) ed_cnt++;
      #50_000 dev_send(mk_frame(i < 2 ? 8'hFE : 8'hFA, 0, 0, 0));
    end
    check(ed_cnt == 3, "ed_transmissions", ed_cnt, 3);
    dev_recv(b, ok);
    check(ok && b == {5'b0, v}, "tx_byte1_retry", b, {5'b0, v});
    #50_000 dev_send(mk_frame(8'hFA, 0, 0, 0));
    wait_drain(200, "led_done_after_retry");

    // 5: silent device -> 4 attempts then led_err
    push_ev(EV_ERR, 8'h00);
    n0 = req_t.size();
    pulse_req(3'b010);
    wait_drain(4 * (TMO + INH) + 2000, "led_err_seen");
    check(req_t.size() - n0 == 4, "attempt_count", req_t.size() - n0, 4);
    for (int i = 0; i < 3 && n0 + i + 1 < req_t.size(); i++) begin
      r = req_t[n0 + i + 1] - req_t[n0 + i];
      check(r >= TMO + INH - 2 && r <= TMO + INH + 2, "attempt_spacing", r, TMO + INH);
    end
    check({ps2_clk_oe, ps2_data_oe, led_busy} == 3'b000, "released_after_err",
          {ps2_clk_oe, ps2_data_oe, led_busy}, 0);

    // 6: async reset during TX_BITS (after edge 2 the host drives ~bit1 of 0xED = 1)
    pulse_req(3'b001);
    r = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && r < 1000) begin
      @(negedge clk);
      r++;
    end
    check(r < 1000, "req_before_reset", r, 0);
    #10_000;
    for (int k = 0; k < 2; k++) begin
      dev_clk = 1'b0;
      #20_000 dev_clk = 1'b1;
      #20_000;
    end
    #237 check(ps2_data_oe == 1'b1, "driving_bit1", ps2_data_oe, 1);
    rst_n = 1'b0;
    #1 check({ps2_clk_oe, ps2_data_oe, led_busy, led_done, led_err, rx_valid, rx_perr, rx_byte} == '0,
             "async_reset_outputs", {ps2_clk_oe, ps2_data_oe, led_busy}, 0);
    #5000 @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check({ps2_clk_oe, ps2_data_oe, led_busy} == 3'b000, "idle_after_reset",
          {ps2_clk_oe, ps2_data_oe, led_busy}, 0);
    f = mk_frame(8'h29, 0, 0, 0);
    expect_frame(f);
    dev_send(f);
    wait_drain(200, "rx_after_reset");
    check(rx_byte == 8'h29, "rx_byte_29", rx_byte, 8'h29);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
